irq_encoder_8_3: RTL and testbench
==================================

Name: irq_encoder_8_3

Overview:
- Sequential 8-to-3 priority encoder with a valid/ack handshake. Inverse of the 3-to-8 decode path.
- Captures up to eight single-cycle request lines (interrupt/exception sources) into a pending register.
- Presents the index of the highest-priority pending line, then retires it on acknowledge.
- Sits between peripheral/exception sources and the processor control logic.
- Decoding out_index to one-hot, with enable = out_valid, must yield exactly the serviced request line.

Parameters:
- None. Width is fixed at 8 requests / 3-bit index.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  8  request pulses; bit i is source i
- enable  input  1  capture enable; when low, req is ignored
- ack  input  1  consumer accepts the presented index
- out_valid  output  1  out_index is valid
- out_index  output  3  encoded index of the presented source
- pending  output  8  current pending register
- overflow  output  1  sticky flag: a request was lost

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of clock.
- Reset dominates all other inputs. It sets pending = 8'h00, out_valid = 0, out_index = 3'd0, overflow = 0, state = IDLE.

Pending register and capture:
- set_mask = enable ? req : 8'h00.
- clr_mask = (state == PRESENT && ack) ? onehot(out_index) : 8'h00.
- pending_next = (pending & ~clr_mask) | set_mask.
- If a bit is cleared and set in the same cycle, set wins and the new event is retained.

Priority and encoding:
- Lowest index wins: bit 0 is highest priority, bit 7 lowest.
- enc(x) returns the index of the lowest set bit of x, or 3'd0 if x is 0.

States:
- IDLE (out_valid = 0):
  - If pending_next != 0: load out_index <= enc(pending_next), out_valid <= 1, go to PRESENT.
  - Otherwise stay in IDLE; out_index holds its last value.
- PRESENT (out_valid = 1):
  - Without ack: out_index is frozen, even if a higher-priority request arrives.
  - With ack and pending_next != 0: load enc(pending_next) and stay in PRESENT. Back-to-back grants, no bubble.
  - With ack and pending_next == 0: out_valid <= 0, go to IDLE.

Latency and throughput:
- A req pulse in cycle N, with the block idle, gives out_valid = 1 in cycle N+1.
- Throughput is one retirement per cycle while ack is held high.

Handshake rules:
- A transfer occurs only in a cycle where out_valid && ack.
- ack while out_valid = 0 is ignored and does not clear pending.
- enable low: new requests are dropped (no overflow), pending is retained, and presentation/ack continue normally.

Overflow:
- Set when, for any i, set_mask[i] = 1, pending[i] = 1, and clr_mask[i] = 0. The request is merged, i.e. lost.
- Cleared only by reset.

Boundary conditions:
- All 8 bits set: indices are retired 0,1,…,7 over 8 consecutive acked cycles.
- Reset asserted mid-PRESENT: out_valid = 0 on the next edge, and the presented request is discarded.

Test Plan:
- Reset check: reset high 2 cycles with req = 8'hFF, enable = 1 -> after release pending = 8'h00, out_valid = 0, out_index = 0, overflow = 0.
- Single request: req = 8'h20 for 1 cycle -> next cycle out_valid = 1, out_index = 5, pending = 8'h20. Ack 1 cycle -> out_valid = 0, pending = 8'h00.
- Priority and hold: req = 8'h80, then one cycle later req = 8'h02 with ack low -> out_index stays 7. Ack -> next out_index = 1, out_valid stays 1. Ack -> out_valid = 0.
- Burst: req = 8'hFF, then ack held high -> out_index sequence 0..7 on consecutive cycles, then out_valid = 0, pending = 8'h00.
- Overflow and set-wins: pending = 8'h08 presented (index 3). req = 8'h08 with ack = 1 -> pending stays 8'h08, out_index = 3, overflow = 0. Repeat req = 8'h08 with ack = 0 -> overflow = 1 and remains 1.
- Enable and spurious ack: enable = 0, req = 8'h10 -> pending unchanged, out_valid = 0. ack = 1 while idle -> no state change. Reset during PRESENT -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/irq_encoder_8_3.sv
// Sequential 8-to-3 priority encoder: captures request pulses into a pending
// register and presents the lowest-index pending source under a valid/ack handshake.

module irq_line_cell (
  input  logic set,
  input  logic clr,
  input  logic cur,
  output logic nxt,
  output logic lost
);
  // Set wins over a same-cycle clear, so a fresh event is never dropped.
  assign nxt  = (cur & ~clr) | set;
  assign lost = set & cur & ~clr;
endmodule

module irq_encoder_8_3 (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       enable,
  input  logic       ack,
  output logic       out_valid,
  output logic [2:0] out_index,
  output logic [7:0] pending,
  output logic       overflow
);
  localparam int NUM_LANES = 8;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_LANES-1:0]   set_mask, clr_mask, pend_d, lost;
  logic [2:0]             idx_d, enc_idx;
  logic                   xfer;

  assign xfer     = (state_q == PRESENT) && ack;
  assign set_mask = enable ? req : '0;
  assign clr_mask = xfer ? (NUM_LANES'(1) << out_index) : '0;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      irq_line_cell u_cell (
        .set  (set_mask[i]),
        .clr  (clr_mask[i]),
        .cur  (pending[i]),
        .nxt  (pend_d[i]),
        .lost (lost[i])
      );
    end
  endgenerate

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    enc_idx = 3'd0;
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (pend_d[i]) enc_idx = 3'(i);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = out_index;
    unique case (state_q)
      IDLE: if (pend_d != '0) begin
        state_d = PRESENT;
        idx_d   = enc_idx;
      end
      PRESENT: if (ack) begin
        if (pend_d != '0) idx_d   = enc_idx;
        else              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      out_index <= 3'd0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_index <= idx_d;
      pending   <= pend_d;
      if (|lost) overflow <= 1'b1;
    end
  end

  assign out_valid = (state_q == PRESENT);

endmodule

// File: tb/tb_irq_encoder_8_3.sv
// Directed bench for irq_encoder_8_3 with hand-computed expectations.

module tb_irq_encoder_8_3;
  logic       clock = 1'b0;
  logic       reset, enable, ack;
  logic [7:0] req;
  logic       out_valid, overflow;
  logic [2:0] out_index;
  logic [7:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  irq_encoder_8_3 dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .enable    (enable),
    .ack       (ack),
    .out_valid (out_valid),
    .out_index (out_index),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; ack = 1'b0; req = 8'hFF;
    step(); step();
    reset = 1'b0; req = 8'h00;
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_index",   32'(out_index), 32'd0);
    chk("rst_ovf",     32'(overflow), 32'd0);

    // Single request
    req = 8'h20; step(); req = 8'h00;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_index", 32'(out_index), 32'd5);
    chk("single_pend",  32'(pending), 32'h20);
    ack = 1'b1; step(); ack = 1'b0;
    chk("single_ack_valid", 32'(out_valid), 32'd0);
    chk("single_ack_pend",  32'(pending), 32'h00);

    // Priority and hold
    req = 8'h80; step();
    req = 8'h02; step(); req = 8'h00;
    chk("hold_index", 32'(out_index), 32'd7);
    chk("hold_pend",  32'(pending), 32'h82);
    ack = 1'b1; step();
    chk("prio_index", 32'(out_index), 32'd1);
    chk("prio_valid", 32'(out_valid), 32'd1);
    step(); ack = 1'b0;
    chk("prio_done_valid", 32'(out_valid), 32'd0);

    // Burst of all eight sources
    req = 8'hFF; step(); req = 8'h00;
    chk("burst_idx0", 32'(out_index), 32'd0);
    ack = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("burst_idx%0d", i), 32'(out_index), 32'(i));
      chk($sformatf("burst_vld%0d", i), 32'(out_valid), 32'd1);
    end
    step(); ack = 1'b0;
    chk("burst_end_valid", 32'(out_valid), 32'd0);
    chk("burst_end_pend",  32'(pending), 32'h00);
    chk("burst_ovf",       32'(overflow), 32'd0);

    // Set wins over clear, then overflow
    req = 8'h08; step(); req = 8'h00;
    chk("ovf_pre_index", 32'(out_index), 32'd3);
    req = 8'h08; ack = 1'b1; step();
    chk("setwin_pend",  32'(pending), 32'h08);
    chk("setwin_index", 32'(out_index), 32'd3);
    chk("setwin_valid", 32'(out_valid), 32'd1);
    chk("setwin_ovf",   32'(overflow), 32'd0);
    ack = 1'b0; step(); req = 8'h00;
    chk("ovf_set", 32'(overflow), 32'd1);
    step();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ovf_drain_valid", 32'(out_valid), 32'd0);
    chk("ovf_sticky2",     32'(overflow), 32'd1);

    // Enable low and spurious ack
    enable = 1'b0; req = 8'h10; step(); req = 8'h00; enable = 1'b1;
    chk("dis_pend",  32'(pending), 32'h00);
    chk("dis_valid", 32'(out_valid), 32'd0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("spur_pend",  32'(pending), 32'h00);
    chk("spur_valid", 32'(out_valid), 32'd0);
    chk("spur_index", 32'(out_index), 32'd3);

    // Reset mid-PRESENT
    req = 8'h04; step(); req = 8'h00;
    chk("pre_rst_index", 32'(out_index), 32'd2);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_pend",  32'(pending), 32'h00);
    chk("mid_rst_index", 32'(out_index), 32'd0);
    chk("mid_rst_ovf",   32'(overflow), 32'd0);
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
